// File: rtl/channel_display_scanner_if.sv
// Display-scanner bundle: four BCD voltage words and controls in, selected channel and 7-seg drive out.
// Carries no timing of its own; every signal is sampled or driven on the scanner clock.
// The bench drives through the master modport and the scanner consumes through the slave modport.
interface channel_display_scanner_if;
  logic [15:0] channel0;
  logic [15:0] channel1;
  logic [15:0] channel2;
  logic [15:0] channel3;
  logic        btn_next;
  logic        auto_mode;
  logic [1:0]  sel_channel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (
    output channel0, channel1, channel2, channel3, btn_next, auto_mode,
    input  sel_channel, an, seg, dp
  );

  modport slave (
    input  channel0, channel1, channel2, channel3, btn_next, auto_mode,
    output sel_channel, an, seg, dp
  );
endinterface

// File: rtl/channel_display_scanner.sv
// Channel display scanner: shows one of four BCD voltage words (X.XXX V) on a 4-digit multiplexed 7-seg display.
// Latency: an/seg/dp are registered one cycle after the digit index changes; the button acts 3 clks after its rising edge.
// No backpressure: the inputs are free-running levels and a snapshot is latched once per frame on the 3->0 index wrap.
// Optional macro CH_ID_EN adds a channel-ID banner ("C - - n") for ID_PERIOD cycles after every channel change.
module channel_display_scanner #(
  parameter int DIGIT_PERIOD = 100000,
  parameter int DWELL_PERIOD = 200000000,
  parameter int ID_PERIOD    = 50000000
) (
  input logic clk,
  input logic rst,
  channel_display_scanner_if.slave bus
);

  localparam int RW = $clog2(DIGIT_PERIOD + 1);
  localparam int DW = $clog2(DWELL_PERIOD + 1);

  logic [RW-1:0] r_refresh;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic          r_armed;   // set at the first 3->0 wrap; the display stays blank until then
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_sel;
  logic          r_btn_s1, r_btn_s2, r_btn_s3;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_refresh_tc;
  logic          w_btn_edge;
  logic          w_dwell_tc;
  logic          w_sel_inc;
  logic          w_banner;
  logic [15:0]   w_chan;
  logic [3:0]    w_nib;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  // Active-low BCD decode; A-F show '-' to flag a corrupt nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase
  endfunction

  assign w_refresh_tc = (r_refresh == RW'(DIGIT_PERIOD - 1));
  assign w_btn_edge   = r_btn_s2 & ~r_btn_s3;
  assign w_dwell_tc   = bus.auto_mode && (r_dwell == DW'(DWELL_PERIOD - 1));
  // A button edge coinciding with the dwell terminal count still yields a single step.
  assign w_sel_inc    = w_btn_edge | w_dwell_tc;

  // Select the channel that will be captured at the next frame boundary.
  always_comb begin
    w_chan = bus.channel0;
    case (r_sel)
      2'd1:    w_chan = bus.channel1;
      2'd2:    w_chan = bus.channel2;
      2'd3:    w_chan = bus.channel3;
      default: w_chan = bus.channel0;
    endcase
  end

  // Two-flop synchronizer for the asynchronous button level, plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 1'b0;
      r_btn_s2 <= 1'b0;
      r_btn_s3 <= 1'b0;
    end else begin
      r_btn_s1 <= bus.btn_next;
      r_btn_s2 <= r_btn_s1;
      r_btn_s3 <= r_btn_s2;
    end
  end

  // Digit refresh counter, digit index, and once-per-frame snapshot of the selected channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
      r_snap    <= 16'h0000;
      r_armed   <= 1'b0;
    end else if (w_refresh_tc) begin
      r_refresh <= '0;
      r_idx     <= r_idx + 2'd1;
      if (r_idx == 2'd3) begin
        r_snap  <= w_chan;
        r_armed <= 1'b1;
      end
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  // Channel selection: button edge or auto-rotation dwell timeout; dwell is parked at 0 in manual mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel   <= 2'd0;
      r_dwell <= '0;
    end else begin
      if (w_sel_inc) r_sel <= r_sel + 2'd1;
      if (!bus.auto_mode || w_sel_inc) r_dwell <= '0;
      else                             r_dwell <= r_dwell + DW'(1);
    end
  end

`ifdef CH_ID_EN
  localparam int IW = $clog2(ID_PERIOD + 1);
  logic [IW-1:0] r_id_cnt;

  // Banner timer: reloads on every channel change, so back-to-back changes restart it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_id_cnt <= '0;
    else if (w_sel_inc)      r_id_cnt <= IW'(ID_PERIOD);
    else if (r_id_cnt != '0) r_id_cnt <= r_id_cnt - IW'(1);
  end

  assign w_banner = (r_id_cnt != '0);
`else
  assign w_banner = 1'b0;
`endif

  // Next digit drive: voltage digit, ID banner, or blank before the first snapshot exists.
  always_comb begin
    w_an  = ~(4'b0001 << r_idx);
    w_nib = r_snap[{r_idx, 2'b00} +: 4];
    w_seg = seg7(w_nib);
    w_dp  = (r_idx != 2'd3);
    if (w_banner) begin
      w_dp = 1'b1;
      case (r_idx)
        2'd3:    w_seg = 7'h46;
        2'd0:    w_seg = seg7({2'b00, r_sel});
        default: w_seg = 7'h3F;
      endcase
    end
    if (!r_armed) begin
      w_an  = 4'b1111;
      w_seg = 7'h7F;
      w_dp  = 1'b1;
    end
  end

  // Registered display outputs; reset blanks them immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign bus.sel_channel = r_sel;
  assign bus.an          = r_an;
  assign bus.seg         = r_seg;
  assign bus.dp          = r_dp;

endmodule

// File: doc/channel_display_scanner.md
Name: channel_display_scanner

Overview:
- Downstream consumer of the 4-channel ADC front end. Takes four 16-bit BCD voltage words (format X.XXX V, digit3 = units) and drives the Basys3 4-digit seven-segment display.
- Shows one selected channel at a time. The channel is chosen by a button or by automatic rotation.
- Time-multiplexes the digits and latches the displayed value once per frame, so a display frame never mixes old and new digits.

Parameters:
- DIGIT_PERIOD, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz).
- DWELL_PERIOD, 200000000: clk cycles per channel in auto mode (2 s).
- ID_PERIOD, 50000000: clk cycles the channel-ID banner is shown. Used only with CH_ID_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- channel0  input  16  BCD word ch0, [15:12] = units digit, [11:0] = three fractional digits
- channel1  input  16  BCD word ch1
- channel2  input  16  BCD word ch2
- channel3  input  16  BCD word ch3
- btn_next  input  1  raw, asynchronous, already-debounced button level
- auto_mode  input  1  1 = rotate channels every DWELL_PERIOD
- sel_channel  output  2  currently selected channel
- an  output  4  digit anodes, active-low, one-hot-zero
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low

Behaviour:
- Reset (async, active-high) sets:
  - sel_channel=0, digit index=0, refresh and dwell counters=0
  - snapshot=16'h0000, an=4'b1111, seg=7'h7F, dp=1
- Refresh counter:
  - Counts 0..DIGIT_PERIOD-1; at the terminal count it wraps to 0 and advances the digit index 0→1→2→3→0.
  - an, seg and dp are registered. They reflect the new index one cycle after the index changes.
- Digit mapping:
  - idx0 → an=4'b1110, snapshot[3:0]
  - idx1 → an=4'b1101, snapshot[7:4]
  - idx2 → an=4'b1011, snapshot[11:8]
  - idx3 → an=4'b0111, snapshot[15:12], dp=0
  - dp=1 for every other index.
- Snapshot: loaded from channel[sel_channel] on the cycle the index wraps 3→0. Input changes between wraps do not reach the display.
- Decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex)
  - Nibbles A–F → 7'h3F ('-'), which marks an invalid BCD nibble.
- Button handling:
  - btn_next passes through a 2-FF synchronizer, then rising-edge detection.
  - An edge increments sel_channel mod 4 (3→0 wraps) and clears the dwell counter.
  - A held button gives exactly one increment.
- Auto mode:
  - When auto_mode=1, the dwell counter counts 0..DWELL_PERIOD-1. At the terminal count sel_channel increments mod 4 and the counter clears.
  - When auto_mode=0, the dwell counter is held at 0.
- Button edge and dwell terminal count in the same cycle → a single increment and the counter clears.
- A reset asserted mid-frame immediately blanks the display. After release, scanning restarts at idx0 with snapshot 0 until the first 3→0 wrap.

Optional Feature:
- Macro CH_ID_EN.
- Defined:
  - Every change of sel_channel starts an ID timer of ID_PERIOD cycles.
  - While the timer runs, the digits show "C" on idx3 (seg 7'h46, dp=1), '-' on idx2 and idx1 (7'h3F), and the channel number on idx0 (decoded 0–3).
  - The snapshot keeps updating underneath; voltage display resumes when the timer expires.
  - A new change during the banner restarts the timer.
- Undefined: no timer logic is built, and the voltage is shown continuously.

Test Plan (DIGIT_PERIOD=4, DWELL_PERIOD=64, ID_PERIOD=32):
- Reset release, channel0=16'h1234, auto_mode=0 → sel_channel=0 and blank until the first wrap. After the wrap, an cycles 1110/1101/1011/0111 every 4 clks with seg 19/30/24/79 (digits 4, 3, 2, 1), and dp=0 only during an=0111.
- Pulse btn_next (held 10 clks) from sel=3 → sel_channel=0 exactly once, 3 clks after the rising edge (2 sync + 1 edge register).
- auto_mode=1, no button → sel_channel steps 0→1→2→3→0 every 64 clks. A btn_next edge at dwell count 63 → a single increment, and the next auto step comes 64 clks later.
- Change channel1 from 16'h0999 to 16'h3300 mid-frame while sel=1 → displayed digits stay 0,9,9,9 until the next 3→0 wrap, then show 3,3,0,0.
- channel2=16'h0A5F, sel=2 → idx2 and idx0 show 7'h3F, idx1 shows 12 (digit 5), idx3 shows 40 (digit 0) with dp=0. Assert rst mid-frame → an=4'b1111 and seg=7'h7F within the same cycle.
- With CH_ID_EN, a button press to sel=2 → for 32 clks the digits show C, -, -, 2 (seg 46, 3F, 3F, 24), then the voltage display returns.
